if_stage_mq: RTL and testbench

//  Parametrised instruction-fetch stage that keeps up to MAX_OUTSTANDING inst-SRAM requests in flight.

---
 rtl/if_stage_mq_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/if_stage_mq.sv | 118 +++++++++++
 tb/tb_if_stage_mq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_mq_pkg.sv
// Shared fetch-stage constants and the fetch-to-decode bus packing helper.
package if_stage_mq_pkg;

    localparam int          FS_TO_DS_BUS_WD = 72;
    localparam logic [5:0]  ECODE_ADE       = 6'h08;
    localparam logic        ESUBCODE_ADEF   = 1'b0;
    localparam logic [31:0] ADEF_INST       = 32'h0010_0000;

    function automatic logic [FS_TO_DS_BUS_WD-1:0] pack_fs_bus(
        input logic        esubcode,
        input logic [5:0]  ecode,
        input logic        ex,
        input logic [31:0] inst,
        input logic [31:0] pc
    );
        return {esubcode, ecode, ex, inst, pc};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with clear; push is registered, head is read combinationally.
// Latency 1 cycle push->head; push while full and pop while empty are ignored.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push & (count != CNT_W'(DEPTH));
    assign do_pop  = pop & (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_stage_mq.sv
// Instruction fetch with up to MAX_OUTSTANDING pipelined SRAM requests and an IBUF to decode.
// Latency: data_ok -> fs_to_ds_valid 1 cycle; requests throttle on IBUF space, stale data dropped by cancel count.
module if_stage_mq
    import if_stage_mq_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4,
    parameter logic [31:0] RESET_PC        = 32'h1c00_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_valid,
    input  logic [31:0]                flush_pc,
    input  logic                       br_valid,
    input  logic [31:0]                br_pc,
    input  logic                       br_stall,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata,
    input  logic                       ds_allowin,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);
    localparam int QCNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int IBCNT_W = $clog2(IBUF_DEPTH + 1);

    logic [31:0]                fetch_pc;
    logic [QCNT_W-1:0]          cancel_cnt;
    logic                       halt;
    logic [QCNT_W-1:0]          inflight;
    logic [QCNT_W-1:0]          live;
    logic [IBCNT_W-1:0]         ibuf_cnt;
    logic [31:0]                pcq_head;
    logic [FS_TO_DS_BUS_WD-1:0] ibuf_din;
    logic                       redirect;
    logic [31:0]                redirect_pc;
    logic                       pc_ok;
    logic                       room;
    logic                       req_fire;
    logic                       resp_keep;
    logic                       adef_fire;
    logic                       ibuf_push;
    logic                       ibuf_pop;

    assign redirect    = flush_valid | br_valid;
    assign redirect_pc = flush_valid ? flush_pc : br_pc;
    assign pc_ok       = fetch_pc[1:0] == 2'b00;
    assign live        = inflight - cancel_cnt;
    // Reserve IBUF slots for every response that will actually be kept.
    assign room        = (int'(ibuf_cnt) + int'(live)) < IBUF_DEPTH;

    assign inst_sram_req   = ~reset & ~halt & ~br_stall & ~redirect & pc_ok
                           & (int'(inflight) < MAX_OUTSTANDING) & room;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wdata = 32'h0;

    assign req_fire  = inst_sram_req & inst_sram_addr_ok;
    assign resp_keep = inst_sram_data_ok & (cancel_cnt == '0) & ~redirect;
    // Raise ADEF only once all older fetches have drained, so it stays in program order.
    assign adef_fire = ~pc_ok & (live == '0) & (int'(ibuf_cnt) < IBUF_DEPTH) & ~redirect & ~halt;
    assign ibuf_push = resp_keep | adef_fire;
    assign ibuf_pop  = fs_to_ds_valid & ds_allowin;
    assign ibuf_din  = adef_fire ? pack_fs_bus(ESUBCODE_ADEF, ECODE_ADE, 1'b1, ADEF_INST, fetch_pc)
                                 : pack_fs_bus(1'b0, 6'h00, 1'b0, inst_sram_rdata, pcq_head);

    assign fs_to_ds_valid = ibuf_cnt != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            cancel_cnt <= '0;
            halt       <= 1'b0;
        end else if (redirect) begin
            fetch_pc   <= redirect_pc;
            halt       <= 1'b0;
            cancel_cnt <= inflight - QCNT_W'(inst_sram_data_ok);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (inst_sram_data_ok && cancel_cnt != '0) cancel_cnt <= cancel_cnt - QCNT_W'(1);
            if (adef_fire) halt <= 1'b1;
        end
    end

    fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (inst_sram_data_ok),
        .head      (pcq_head),
        .count     (inflight)
    );

    fetch_fifo #(.WIDTH(FS_TO_DS_BUS_WD), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (ibuf_push),
        .push_data (ibuf_din),
        .pop       (ibuf_pop),
        .head      (fs_to_ds_bus),
        .count     (ibuf_cnt)
    );

    a_data_ok_has_request: assert property (@(posedge clk) disable iff (reset)
        inst_sram_data_ok |-> inflight != '0);

endmodule

// File: tb/tb_if_stage_mq.sv
// Directed and randomized-redirect bench for if_stage_mq with an in-order SRAM-like slave model.
module tb_if_stage_mq;
    localparam logic [31:0] RST_PC   = 32'h1c00_0000;
    localparam logic [31:0] KEY      = 32'h5a5a_a5a5;
    localparam logic [71:0] ADEF_BUS = {1'b0, 6'h08, 1'b1, 32'h0010_0000, 32'h1c00_0102};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_pc = '0;
    logic        br_stall = 1'b0;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;
    logic        ds_allowin = 1'b0;
    logic        fs_to_ds_valid;
    logic [71:0] fs_to_ds_bus;

    int checks = 0;
    int errors = 0;
    bit aok_rand = 0, dok_rand = 0, lat_rand = 0;
    int lat_base = 1;
    int cyc = 0;
    int ep = 0;
    logic [31:0] sl_addr[$];
    int          sl_rdy[$];
    logic [31:0] iss_q[$];
    int          iss_cyc_q[$];
    int          resp_cyc_q[$];
    logic [71:0] del_q[$];
    int          del_cyc_q[$];
    int          del_ep_q[$];
    logic [31:0] tgts[$];

    if_stage_mq #(.MAX_OUTSTANDING(2), .IBUF_DEPTH(4), .RESET_PC(32'h1c00_0000)) dut (
        .clk(clk), .reset(reset),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .br_valid(br_valid), .br_pc(br_pc), .br_stall(br_stall),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata), .ds_allowin(ds_allowin),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
    );

    always #5 clk = ~clk;

    // Slave and monitor: all inputs settle at negedge, this samples what the next posedge will see.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (reset) begin
            sl_addr.delete();
            sl_rdy.delete();
            inst_sram_addr_ok = 1'b0;
            inst_sram_data_ok = 1'b0;
        end else begin
            inst_sram_addr_ok = aok_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sl_addr.size() != 0 && sl_rdy[0] <= cyc && (!dok_rand || $urandom_range(0, 1) == 1)) begin
                inst_sram_data_ok = 1'b1;
                inst_sram_rdata   = sl_addr[0] ^ KEY;
                void'(sl_addr.pop_front());
                void'(sl_rdy.pop_front());
                resp_cyc_q.push_back(cyc);
            end else begin
                inst_sram_data_ok = 1'b0;
            end
            if (inst_sram_req && inst_sram_addr_ok) begin
                iss_q.push_back(inst_sram_addr);
                iss_cyc_q.push_back(cyc);
                sl_addr.push_back(inst_sram_addr);
                sl_rdy.push_back(cyc + lat_base + (lat_rand ? int'($urandom_range(0, 3)) : 0));
            end
            if (fs_to_ds_valid && ds_allowin && !flush_valid && !br_valid) begin
                del_q.push_back(fs_to_ds_bus);
                del_cyc_q.push_back(cyc);
                del_ep_q.push_back(ep);
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; flush_valid = 1'b0; br_valid = 1'b0; br_stall = 1'b0;
        repeat (2) @(negedge clk);
        iss_q.delete(); iss_cyc_q.delete(); resp_cyc_q.delete();
        del_q.delete(); del_cyc_q.delete(); del_ep_q.delete();
        reset = 1'b0;
    endtask

    task automatic set_slave(input bit rnd, input int lat);
        aok_rand = rnd; dok_rand = rnd; lat_rand = rnd; lat_base = lat;
    endtask

    task automatic test_reset();
        set_slave(0, 1);
        ds_allowin = 1'b1;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #2;
        checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", inst_sram_req); end
        checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fs_to_ds_valid); end
        checks++; if (inst_sram_addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", inst_sram_addr, RST_PC); end
        checks++; if (inst_sram_wr !== 1'b0 || inst_sram_wstrb !== 4'h0 || inst_sram_wdata !== 32'h0)
            begin errors++; $display("FAIL tie_write: got wr=%b wstrb=%h wdata=%h want 0", inst_sram_wr, inst_sram_wstrb, inst_sram_wdata); end
        checks++; if (inst_sram_size !== 2'b10) begin errors++; $display("FAIL tie_size: got %b want 10", inst_sram_size); end
        // Mid-operation reset with a full IBUF
        @(negedge clk); reset = 1'b0; ds_allowin = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        checks++; if (fs_to_ds_valid !== 1'b1) begin errors++; $display("FAIL prefill_valid: got %b want 1", fs_to_ds_valid); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #2;
        checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", fs_to_ds_valid); end
        checks++; if (inst_sram_addr !== RST_PC) begin errors++; $display("FAIL midreset_addr: got %h want %h", inst_sram_addr, RST_PC); end
        @(negedge clk); reset = 1'b0; #2;
        checks++; if (inst_sram_req !== 1'b1) begin errors++; $display("FAIL postreset_req: got %b want 1", inst_sram_req); end
    endtask

    task automatic test_sequential();
        set_slave(0, 1);
        ds_allowin = 1'b1;
        apply_reset();
        repeat (16) @(negedge clk);
        checks++; if (iss_q.size() < 8) begin errors++; $display("FAIL seq_issue_count: got %0d want >=8", iss_q.size()); end
        for (int i = 0; i < 8 && i < iss_q.size(); i++) begin
            checks++; if (iss_q[i] !== RST_PC + 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, iss_q[i], RST_PC + 32'(4 * i)); end
            checks++; if (iss_cyc_q[i] != iss_cyc_q[0] + i) begin errors++; $display("FAIL seq_rate[%0d]: got cycle %0d want %0d", i, iss_cyc_q[i], iss_cyc_q[0] + i); end
        end
        checks++; if (del_q.size() < 6) begin errors++; $display("FAIL seq_deliver_count: got %0d want >=6", del_q.size()); end
        for (int i = 0; i < 6 && i < del_q.size(); i++) begin
            checks++; if (del_q[i] !== {8'h00, (RST_PC + 32'(4 * i)) ^ KEY, RST_PC + 32'(4 * i)})
                begin errors++; $display("FAIL seq_bus[%0d]: got %h want pc %h", i, del_q[i], RST_PC + 32'(4 * i)); end
        end
        if (del_q.size() > 0 && resp_cyc_q.size() > 0 && iss_q.size() > 0) begin
            checks++; if (resp_cyc_q[0] != iss_cyc_q[0] + 1) begin errors++; $display("FAIL seq_resp_lat: got %0d want %0d", resp_cyc_q[0], iss_cyc_q[0] + 1); end
            checks++; if (del_cyc_q[0] != resp_cyc_q[0] + 1) begin errors++; $display("FAIL seq_ibuf_lat: got %0d want %0d", del_cyc_q[0], resp_cyc_q[0] + 1); end
        end
    endtask

    task automatic test_backpressure();
        set_slave(0, 1);
        ds_allowin = 1'b0;
        apply_reset();
        repeat (12) @(negedge clk);
        #2;
        checks++; if (iss_q.size() != 4) begin errors++; $display("FAIL bp_issue_count: got %0d want 4", iss_q.size()); end
        checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL bp_req_held: got %b want 0", inst_sram_req); end
        checks++; if (fs_to_ds_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", fs_to_ds_valid); end
        @(negedge clk); ds_allowin = 1'b1; #2;
        checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL bp_req_same_cycle: got %b want 0", inst_sram_req); end
        @(negedge clk); #2;
        checks++; if (inst_sram_req !== 1'b1) begin errors++; $display("FAIL bp_req_resume: got %b want 1", inst_sram_req); end
        repeat (10) @(negedge clk);
        checks++; if (del_q.size() < 5) begin errors++; $display("FAIL bp_deliver_count: got %0d want >=5", del_q.size()); end
        for (int i = 0; i < 5 && i < del_q.size(); i++) begin
            checks++; if (del_q[i][31:0] !== RST_PC + 32'(4 * i)) begin errors++; $display("FAIL bp_pc[%0d]: got %h want %h", i, del_q[i][31:0], RST_PC + 32'(4 * i)); end
        end
    endtask

    task automatic test_branch_cancel();
        int n = 0;
        int bad = 0;
        set_slave(0, 4);
        ds_allowin = 1'b1;
        apply_reset();
        while (iss_q.size() < 2 && n < 20) begin @(negedge clk); n++; end
        checks++; if (iss_q.size() < 2) begin errors++; $display("FAIL br_wait_two: got %0d requests want 2", iss_q.size()); end
        br_valid = 1'b1; br_pc = 32'h1c00_0100;
        @(negedge clk); br_valid = 1'b0; #2;
        checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL br_ibuf_empty: got %b want 0", fs_to_ds_valid); end
        repeat (20) @(negedge clk);
        checks++; if (iss_q.size() < 3 || iss_q[2] !== 32'h1c00_0100) begin errors++; $display("FAIL br_next_addr: got %0d reqs want third addr 1c000100", iss_q.size()); end
        checks++; if (del_q.size() < 1 || del_q[0][31:0] !== 32'h1c00_0100) begin errors++; $display("FAIL br_first_pc: got %0d entries want first pc 1c000100", del_q.size()); end
        foreach (del_q[i]) if (del_q[i][31:0] < 32'h1c00_0100) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL br_stale_dropped: got %0d stale deliveries want 0", bad); end
    endtask

    task automatic test_flush_priority();
        int n = 0;
        int bad = 0;
        set_slave(0, 2);
        ds_allowin = 1'b1;
        apply_reset();
        while (iss_q.size() < 2 && n < 20) begin @(negedge clk); n++; end
        checks++; if (iss_q.size() < 2) begin errors++; $display("FAIL fl_wait_two: got %0d requests want 2", iss_q.size()); end
        flush_valid = 1'b1; flush_pc = 32'h1c00_8000;
        br_valid = 1'b1;    br_pc = 32'h1c00_0200;
        @(negedge clk); flush_valid = 1'b0; br_valid = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (iss_q.size() < 3 || iss_q[2] !== 32'h1c00_8000) begin errors++; $display("FAIL fl_next_addr: got %0d reqs want third addr 1c008000", iss_q.size()); end
        checks++; if (del_q.size() < 2 || del_q[0][31:0] !== 32'h1c00_8000 || del_q[1][31:0] !== 32'h1c00_8004)
            begin errors++; $display("FAIL fl_cancel_one: got %0d entries want pcs 1c008000,1c008004 first", del_q.size()); end
        foreach (del_q[i]) if (del_q[i][31:12] !== 20'h1c008) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL fl_only_flush_path: got %0d foreign pcs want 0", bad); end
    endtask

    task automatic test_adef();
        int n_iss;
        int n_del;
        set_slave(0, 1);
        ds_allowin = 1'b0;
        apply_reset();
        repeat (10) @(negedge clk);
        br_valid = 1'b1; br_pc = 32'h1c00_0102;
        n_iss = iss_q.size(); n_del = del_q.size();
        @(negedge clk); br_valid = 1'b0; #2;
        checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL adef_clear_full: got %b want 0", fs_to_ds_valid); end
        @(negedge clk); #2;
        checks++; if (fs_to_ds_valid !== 1'b1) begin errors++; $display("FAIL adef_valid: got %b want 1", fs_to_ds_valid); end
        checks++; if (fs_to_ds_bus !== ADEF_BUS) begin errors++; $display("FAIL adef_bus: got %h want %h", fs_to_ds_bus, ADEF_BUS); end
        @(negedge clk); ds_allowin = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        checks++; if (iss_q.size() != n_iss) begin errors++; $display("FAIL adef_no_req: got %0d want %0d", iss_q.size(), n_iss); end
        checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL adef_halt_req: got %b want 0", inst_sram_req); end
        checks++; if (del_q.size() != n_del + 1) begin errors++; $display("FAIL adef_once: got %0d want %0d", del_q.size(), n_del + 1); end
        @(negedge clk); flush_valid = 1'b1; flush_pc = 32'h1c00_8000;
        @(negedge clk); flush_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (iss_q.size() <= n_iss || iss_q[n_iss] !== 32'h1c00_8000) begin errors++; $display("FAIL adef_resume_addr: got %0d reqs want resume at 1c008000", iss_q.size()); end
        checks++; if (del_q.size() < n_del + 2 || del_q[n_del + 1][31:0] !== 32'h1c00_8000)
            begin errors++; $display("FAIL adef_resume_pc: got %0d entries want pc 1c008000 after ADEF", del_q.size()); end
    endtask

    task automatic test_random();
        int cur = -1;
        logic [31:0] exp_pc = '0;
        set_slave(1, 1);
        ds_allowin = 1'b1;
        apply_reset();
        ep = 0; tgts.delete(); tgts.push_back(RST_PC);
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            ds_allowin  = 1'($urandom_range(0, 1));
            br_stall    = ($urandom_range(0, 7) == 0);
            flush_valid = 1'b0; br_valid = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                flush_pc = RST_PC + 32'($urandom_range(0, 255) * 4);
                br_pc    = 32'h1c01_0000 + 32'($urandom_range(0, 255) * 4);
                case ($urandom_range(0, 2))
                    0: begin flush_valid = 1'b1; tgts.push_back(flush_pc); end
                    1: begin br_valid = 1'b1; tgts.push_back(br_pc); end
                    default: begin flush_valid = 1'b1; br_valid = 1'b1; tgts.push_back(flush_pc); end
                endcase
                ep++;
            end
        end
        @(negedge clk);
        flush_valid = 1'b0; br_valid = 1'b0; br_stall = 1'b0; ds_allowin = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (del_q.size() < 200) begin errors++; $display("FAIL rnd_progress: got %0d deliveries want >=200", del_q.size()); end
        for (int i = 0; i < del_q.size(); i++) begin
            if (del_ep_q[i] != cur) begin cur = del_ep_q[i]; exp_pc = tgts[cur]; end
            checks++; if (del_q[i] !== {8'h00, exp_pc ^ KEY, exp_pc})
                begin errors++; $display("FAIL rnd_seq[%0d]: got %h want pc %h epoch %0d", i, del_q[i], exp_pc, cur); end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_cancel();
        test_flush_priority();
        test_adef();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
